pwm_sine_generator: RTL and testbench



---
 rtl/pwm_sine_generator.sv | 64 ++++++
 tb/tb_pwm_sine_generator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sine_generator.sv
// Lab-board function generator: quadrature oscillator producing sine, half-wave
// and full-wave rectified outputs, plus a fixed-period PWM with a glitch-free duty reload.
module pwm_sine_generator #(
  parameter int SHIFT    = 6,
  parameter int AMP_INIT = 30000,
  parameter int PWM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  output logic [7:0]       sin,
  output logic [7:0]       half,
  output logic [7:0]       full,
  output logic             pwm_out
);

  logic signed [15:0] s_q, s_d;
  logic signed [15:0] c_q, c_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [PWM_W-1:0]   dq_q, dq_d;
  logic               pwm_q, pwm_d;
  logic [7:0]         h;
  logic [7:0]         h_mag;

  always_comb begin
    // NOTE: blocking assignments here are deliberate: c_d must be computed from
    // the freshly updated s_d in the same evaluation, which keeps the orbit closed.
    s_d   = s_q + (c_q >>> SHIFT);
    c_d   = c_q - (s_d >>> SHIFT);
    cnt_d = cnt_q + PWM_W'(1);
    dq_d  = (cnt_q == '1) ? duty : dq_q;
    pwm_d = (cnt_q < dq_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      s_q   <= '0;
      c_q   <= 16'(AMP_INIT);
      cnt_q <= '0;
      dq_q  <= duty;
      pwm_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      dq_q  <= dq_d;
      pwm_q <= pwm_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    h     = s_q[15:8];
    h_mag = h[7] ? (8'd0 - h) : h;
    sin   = h + 8'd128;
    half  = s_q[15] ? 8'd128 : sin;
    full  = 8'd128 + h_mag;
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_sine_generator.sv
// Self-checking bench for pwm_sine_generator: randomized duty stimulus against an
// arithmetic reference model, plus waveform property checks on the sine outputs.
module tb_pwm_sine_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] duty;
  logic [7:0] sin, half, full;
  logic       pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  pwm_sine_generator dut (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty),
    .sin    (sin),
    .half   (half),
    .full   (full),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model, expressed as plain integer arithmetic.
  int m_s, m_c, m_pos, m_duty_active;
  bit m_pwm, m_rst;
  int cyc = 0;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_update();
    m_rst = rst;
    if (rst) begin
      m_s = 0; m_c = 30000; m_pos = 0; m_duty_active = duty; m_pwm = 0;
    end else begin
      m_pwm = (m_pos < m_duty_active);
      if (m_pos == 255) m_duty_active = duty;
      m_pos = (m_pos + 1) % 256;
      m_s = m_s + floor_div(m_c, 64);
      m_c = m_c - floor_div(m_s, 64);
    end
  endtask

  // Waveform property accumulators.
  int viol_range = 0, viol_neg = 0, viol_pos = 0, viol_space = 0;
  int n_spacing = 0, last_cross = -1, prev_s = 0, peak = -999;
  bit prev_valid = 0;

  task automatic step();
    int h_exp, sin_exp, sv, hv;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    h_exp   = floor_div(m_s, 256);
    sin_exp = (h_exp + 128 + 256) % 256;
    check("sin",  sin,  sin_exp);
    check("half", half, (m_s < 0) ? 128 : sin_exp);
    check("full", full, (128 + ((h_exp < 0) ? -h_exp : h_exp)) % 256);
    check("pwm",  pwm_out, m_pwm);
    check("s",    dut.s_q, m_s);
    check("c",    dut.c_q, m_c);
    if (m_rst) begin
      prev_valid = 0;
      last_cross = -1;
    end else begin
      sv = dut.s_q;
      hv = floor_div(sv, 256);
      if (sin < 8 || sin > 248) viol_range++;
      if (sv < 0) begin
        if (half != 128) viol_neg++;
        if (full != 256 - sin) viol_neg++;
        if (full < 128) viol_neg++;
      end else if (half != sin || full != sin) begin
        viol_pos++;
      end
      if (prev_valid && prev_s < 0 && sv >= 0) begin
        if (last_cross >= 0) begin
          n_spacing++;
          if (cyc - last_cross < 400 || cyc - last_cross > 405) viol_space++;
        end
        last_cross = cyc;
      end
      prev_s = sv;
      prev_valid = 1;
      if (hv > peak) peak = hv;
    end
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (m_pos != target && k < 300) begin
      step();
      k++;
    end
    check("wait_pos_reached", m_pos, target);
  endtask

  logic [7:0] ref_sin [0:499];
  bit         pw_hist [1:256];

  initial begin
    int highs, first_hi, last_hi, low_idx, mism;

    rst = 1'b1;
    duty = 8'd8;
    step();
    step();
    check("rst_s",    dut.s_q,   0);
    check("rst_cnt",  dut.cnt_q, 0);
    check("rst_pwm",  pwm_out,   0);
    check("rst_sin",  sin,  128);
    check("rst_half", half, 128);
    check("rst_full", full, 128);

    rst = 1'b0;
    step();
    check("first_s",   dut.s_q, 468);
    check("first_c",   dut.c_q, 29993);
    check("first_sin", sin, 129);
    check("first_pwm", pwm_out, 1);
    ref_sin[0] = sin;
    pw_hist[1] = pwm_out;

    for (int i = 2; i <= 30000; i++) begin
      if (i > 512 && $urandom_range(0, 299) == 0) duty = 8'($urandom);
      step();
      if (i <= 500) ref_sin[i-1] = sin;
      if (i <= 256) pw_hist[i] = pwm_out;
    end

    highs = 0; first_hi = -1; last_hi = -1;
    for (int k = 1; k <= 256; k++) begin
      if (pw_hist[k]) begin
        highs++;
        if (first_hi < 0) first_hi = k;
        last_hi = k;
      end
    end
    check("duty8_high_count", highs, 8);
    check("duty8_first_high", first_hi, 1);
    check("duty8_last_high",  last_hi, 8);

    check("sin_range_viol",  viol_range, 0);
    check("neg_half_viol",   viol_neg, 0);
    check("pos_half_viol",   viol_pos, 0);
    check("zc_spacing_viol", viol_space, 0);
    check("zc_count_ok",     n_spacing >= 70, 1);
    check("peak_h_ok",       (peak >= 114 && peak <= 118), 1);

    // duty = 0, changed mid-period
    wait_pos(128);
    duty = 8'd0;
    wait_pos(0);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      highs += pwm_out;
    end
    check("duty0_high_count", highs, 0);

    // duty = 255 changed mid-period: no effect until the period boundary
    wait_pos(100);
    duty = 8'd255;
    highs = 0;
    for (int k = 0; k < 156; k++) begin
      step();
      highs += pwm_out;
    end
    check("duty255_delayed", highs, 0);
    check("duty255_at_boundary", m_pos, 0);
    highs = 0; low_idx = -1;
    for (int k = 0; k < 256; k++) begin
      step();
      highs += pwm_out;
      if (!pwm_out) low_idx = k;
    end
    check("duty255_high_count", highs, 255);
    check("duty255_low_slot",   low_idx, 255);

    // Reset mid-run, then the start-up sequence must repeat exactly
    repeat ($urandom_range(10, 300)) step();
    rst = 1'b1;
    duty = 8'($urandom);
    step();
    check("rst2_cnt",  dut.cnt_q, 0);
    check("rst2_pwm",  pwm_out, 0);
    check("rst2_s",    dut.s_q, 0);
    check("rst2_sin",  sin,  128);
    check("rst2_half", half, 128);
    check("rst2_full", full, 128);
    rst = 1'b0;
    step();
    check("rst2_first_s", dut.s_q, 468);
    mism = (sin != ref_sin[0]) ? 1 : 0;
    for (int i = 1; i < 500; i++) begin
      step();
      if (sin != ref_sin[i]) mism++;
    end
    check("restart_seq_mismatches", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
